// File: rtl/cva6_lsu_mem_pkg.sv
// Shared constants and types for the LSU memory responder.
// Both the top level and the per-channel sub-module import this package.
package cva6_lsu_mem_pkg;

  localparam int ADDR_W                = 32;
  localparam int DEFAULT_LOAD_LATENCY  = 3;
  localparam int DEFAULT_STORE_LATENCY = 3;
  localparam int DEFAULT_DEPTH         = 2;
  localparam int CNT_W                 = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  // Value loaded into the wait counter when a head request starts its countdown.
  // A latency of 1 skips WAIT entirely, so the value is irrelevant there.
  function automatic logic [CNT_W-1:0] wait_ctr_init(input int latency);
    return (latency > 1) ? CNT_W'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/cva6_lsu_mem_responder_if.sv
// Request/response bundle between an LSU and the memory responder.
// master = LSU side, slave = responder side.
interface cva6_lsu_mem_responder_if;
  import cva6_lsu_mem_pkg::*;

  logic              req_valid;
  logic              req_is_load;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              load_mem_resp;
  logic              store_mem_resp;
  logic [ADDR_W-1:0] load_resp_addr;
  logic [ADDR_W-1:0] store_resp_addr;
  logic [CNT_W-1:0]  load_pending;
  logic [CNT_W-1:0]  store_pending;

  modport master (
    output req_valid, req_is_load, req_addr,
    input  req_ready, load_mem_resp, store_mem_resp,
    input  load_resp_addr, store_resp_addr, load_pending, store_pending
  );

  modport slave (
    input  req_valid, req_is_load, req_addr,
    output req_ready, load_mem_resp, store_mem_resp,
    output load_resp_addr, store_resp_addr, load_pending, store_pending
  );

endinterface

// File: rtl/cva6_lsu_resp_channel.sv
// One response channel: address FIFO, occupancy count and a latency FSM.
// The head of the FIFO is answered LATENCY cycles after it became the head
// (after acceptance when the channel was empty, else after the previous response).
module cva6_lsu_resp_channel
  import cva6_lsu_mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LOAD_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              full_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic [CNT_W-1:0]  pending_o
);

  localparam int               PTR_W        = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CTR_INIT     = wait_ctr_init(LATENCY);
  localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(DEPTH);
  localparam bit               SINGLE_CYCLE = (LATENCY == 1);

  logic [ADDR_W-1:0] mem [DEPTH];

  chan_state_e       state_reg;
  logic [CNT_W-1:0]  ctr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic              resp_reg;
  logic [ADDR_W-1:0] resp_addr_reg;

  logic              push_ok;
  logic              pop;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [ADDR_W-1:0] next_head;

  assign full_o      = (count_reg == DEPTH_CNT);
  assign resp_o      = resp_reg;
  assign resp_addr_o = resp_addr_reg;
  assign pending_o   = count_reg;

  // Push/pop qualification, next occupancy and the address of the head after a pop.
  always_comb begin
    push_ok    = push_i && !full_o;
    pop        = (state_reg == RESP);
    count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
    rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
    // With a single entry left, the new head is whatever is being pushed now.
    next_head  = (count_reg == CNT_W'(1)) ? push_addr_i : mem[rd_ptr_inc];
  end

  // FIFO storage write port; no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_addr_i;
    end
  end

  // Latency FSM with registered response pulse/address, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      ctr_reg       <= '0;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      resp_reg      <= 1'b0;
      resp_addr_reg <= '0;
    end else begin
      count_reg     <= count_next;
      resp_reg      <= 1'b0;
      resp_addr_reg <= '0;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case (state_reg)
        IDLE: begin
          if (push_ok) begin
            if (SINGLE_CYCLE) begin
              state_reg     <= RESP;
              resp_reg      <= 1'b1;
              resp_addr_reg <= push_addr_i;
            end else begin
              state_reg <= WAIT;
              ctr_reg   <= CTR_INIT;
            end
          end
        end
        WAIT: begin
          if (ctr_reg == '0) begin
            state_reg     <= RESP;
            resp_reg      <= 1'b1;
            resp_addr_reg <= mem[rd_ptr_reg];
          end else begin
            ctr_reg <= ctr_reg - CNT_W'(1);
          end
        end
        RESP: begin
          if (count_next == '0) begin
            state_reg <= IDLE;
          end else if (SINGLE_CYCLE) begin
            state_reg     <= RESP;
            resp_reg      <= 1'b1;
            resp_addr_reg <= next_head;
          end else begin
            state_reg <= WAIT;
            ctr_reg   <= CTR_INIT;
          end
        end
        default: begin
          state_reg <= IDLE;
          ctr_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_responder.sv
// Memory responder for the CVA6 LSU: steers each request into the load or
// store channel and exposes the two channels' responses and occupancy.
// Channel index 1 is the load channel, index 0 the store channel.
module cva6_lsu_mem_responder
  import cva6_lsu_mem_pkg::*;
#(
  parameter int LOAD_LATENCY  = DEFAULT_LOAD_LATENCY,
  parameter int STORE_LATENCY = DEFAULT_STORE_LATENCY,
  parameter int DEPTH         = DEFAULT_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_is_load_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              load_mem_resp_o,
  output logic              store_mem_resp_o,
  output logic [ADDR_W-1:0] load_resp_addr_o,
  output logic [ADDR_W-1:0] store_resp_addr_o,
  output logic [CNT_W-1:0]  load_pending_o,
  output logic [CNT_W-1:0]  store_pending_o
);

  logic [1:0]        chan_push;
  logic [1:0]        chan_full;
  logic [1:0]        chan_resp;
  logic [ADDR_W-1:0] chan_resp_addr [2];
  logic [CNT_W-1:0]  chan_pending   [2];

  // Ready reflects only the channel the current request would go to.
  assign req_ready_o = !chan_full[req_is_load_i];

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    localparam int LAT = (gi == 1) ? LOAD_LATENCY : STORE_LATENCY;

    assign chan_push[gi] = req_valid_i && !chan_full[gi] &&
                           ((gi == 1) ? req_is_load_i : !req_is_load_i);

    cva6_lsu_resp_channel #(
      .LATENCY (LAT),
      .DEPTH   (DEPTH)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (chan_push[gi]),
      .push_addr_i (req_addr_i),
      .full_o      (chan_full[gi]),
      .resp_o      (chan_resp[gi]),
      .resp_addr_o (chan_resp_addr[gi]),
      .pending_o   (chan_pending[gi])
    );
  end

  assign load_mem_resp_o   = chan_resp[1];
  assign store_mem_resp_o  = chan_resp[0];
  assign load_resp_addr_o  = chan_resp_addr[1];
  assign store_resp_addr_o = chan_resp_addr[0];
  assign load_pending_o    = chan_pending[1];
  assign store_pending_o   = chan_pending[0];

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
// Directed bench for cva6_lsu_mem_responder: a default-latency instance and a
// LOAD_LATENCY=1 instance share clock and reset. Inputs change on the falling
// edge, outputs are sampled on the falling edge after the accepting rising edge.
module tb_cva6_lsu_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cva6_lsu_mem_responder_if bus ();
  cva6_lsu_mem_responder_if fbus ();

  cva6_lsu_mem_responder #(
    .LOAD_LATENCY (3), .STORE_LATENCY (3), .DEPTH (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (bus.req_valid),
    .req_is_load_i     (bus.req_is_load),
    .req_addr_i        (bus.req_addr),
    .req_ready_o       (bus.req_ready),
    .load_mem_resp_o   (bus.load_mem_resp),
    .store_mem_resp_o  (bus.store_mem_resp),
    .load_resp_addr_o  (bus.load_resp_addr),
    .store_resp_addr_o (bus.store_resp_addr),
    .load_pending_o    (bus.load_pending),
    .store_pending_o   (bus.store_pending)
  );

  cva6_lsu_mem_responder #(
    .LOAD_LATENCY (1), .STORE_LATENCY (3), .DEPTH (2)
  ) dut_fast (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (fbus.req_valid),
    .req_is_load_i     (fbus.req_is_load),
    .req_addr_i        (fbus.req_addr),
    .req_ready_o       (fbus.req_ready),
    .load_mem_resp_o   (fbus.load_mem_resp),
    .store_mem_resp_o  (fbus.store_mem_resp),
    .load_resp_addr_o  (fbus.load_resp_addr),
    .store_resp_addr_o (fbus.store_resp_addr),
    .load_pending_o    (fbus.load_pending),
    .store_pending_o   (fbus.store_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic [31:0] a);
    bus.req_valid   = v;
    bus.req_is_load = ld;
    bus.req_addr    = a;
    if (v) $display("req  %s addr=%h", ld ? "load " : "store", a);
  endtask

  task automatic fdrive(input logic v, input logic ld, input logic [31:0] a);
    fbus.req_valid   = v;
    fbus.req_is_load = ld;
    fbus.req_addr    = a;
    if (v) $display("req  fast %s addr=%h", ld ? "load " : "store", a);
  endtask

  // One line per completed response on either instance.
  always @(negedge clk) begin
    if (bus.load_mem_resp)   $display("resp load  addr=%h", bus.load_resp_addr);
    if (bus.store_mem_resp)  $display("resp store addr=%h", bus.store_resp_addr);
    if (fbus.load_mem_resp)  $display("resp fast load addr=%h", fbus.load_resp_addr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        exp_l, exp_s;
    logic [31:0] exp_la, exp_sa;

    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h0);
    fdrive(1'b0, 1'b1, 32'h0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_load_resp",  32'(bus.load_mem_resp), 32'd0);
    check("rst_store_resp", 32'(bus.store_mem_resp), 32'd0);
    check("rst_load_addr",  bus.load_resp_addr, 32'd0);
    check("rst_store_addr", bus.store_resp_addr, 32'd0);
    check("rst_load_pend",  32'(bus.load_pending), 32'd0);
    check("rst_store_pend", 32'(bus.store_pending), 32'd0);
    #1 check("rst_ready_load", 32'(bus.req_ready), 32'd1);
    drive(1'b0, 1'b0, 32'h0);
    #1 check("rst_ready_store", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;

    // Single load, latency 3
    drive(1'b1, 1'b1, 32'hcad);
    #1 check("A_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("A_lresp_k%0d", k), 32'(bus.load_mem_resp), 32'(k == 3));
      check($sformatf("A_laddr_k%0d", k), bus.load_resp_addr, (k == 3) ? 32'hcad : 32'h0);
      check($sformatf("A_sresp_k%0d", k), 32'(bus.store_mem_resp), 32'd0);
      if (k == 1) begin
        check("A_pend", 32'(bus.load_pending), 32'd1);
        drive(1'b0, 1'b0, 32'hdeadbeef);
      end
    end

    // Back-to-back loads fill the channel, third load refused, store still taken
    drive(1'b1, 1'b1, 32'h100);
    #1 check("B_ready0", 32'(bus.req_ready), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_l  = (k == 3) || (k == 6);
      exp_la = (k == 3) ? 32'h100 : (k == 6) ? 32'h104 : 32'h0;
      exp_s  = (k == 6);
      exp_sa = (k == 6) ? 32'hbee : 32'h0;
      check($sformatf("B_lresp_k%0d", k), 32'(bus.load_mem_resp), 32'(exp_l));
      check($sformatf("B_laddr_k%0d", k), bus.load_resp_addr, exp_la);
      check($sformatf("B_sresp_k%0d", k), 32'(bus.store_mem_resp), 32'(exp_s));
      check($sformatf("B_saddr_k%0d", k), bus.store_resp_addr, exp_sa);
      check($sformatf("B_pend_le2_k%0d", k), 32'(bus.load_pending <= 4'd2), 32'd1);
      case (k)
        1: begin
          drive(1'b1, 1'b1, 32'h104);
          #1 check("B_ready1", 32'(bus.req_ready), 32'd1);
        end
        2: begin
          check("B_pend_full", 32'(bus.load_pending), 32'd2);
          drive(1'b1, 1'b1, 32'h108);
          #1 check("B_ready_full", 32'(bus.req_ready), 32'd0);
        end
        3: begin
          check("B_pend_still_full", 32'(bus.load_pending), 32'd2);
          drive(1'b1, 1'b0, 32'hbee);
          #1 check("B_ready_store", 32'(bus.req_ready), 32'd1);
        end
        4: begin
          check("B_lpend_k4", 32'(bus.load_pending), 32'd1);
          check("B_spend_k4", 32'(bus.store_pending), 32'd1);
          drive(1'b0, 1'b1, 32'h55aa55aa);
        end
        default: ;
      endcase
    end

    // Reset one cycle after a load is accepted
    drive(1'b1, 1'b1, 32'h300);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("D_lpend", 32'(bus.load_pending), 32'd0);
    check("D_spend", 32'(bus.store_pending), 32'd0);
    #1 check("D_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("D_no_resp_%0d", k), 32'(bus.load_mem_resp), 32'd0);
    end

    // LOAD_LATENCY 1: immediate and back-to-back responses, push during pop
    fdrive(1'b1, 1'b1, 32'ha0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_la = (k == 1) ? 32'ha0 : (k == 2) ? 32'ha4 : (k == 3) ? 32'ha8 : 32'h0;
      check($sformatf("E_lresp_k%0d", k), 32'(fbus.load_mem_resp), 32'(k <= 3));
      check($sformatf("E_laddr_k%0d", k), fbus.load_resp_addr, exp_la);
      case (k)
        1: fdrive(1'b1, 1'b1, 32'ha4);
        2: begin
          check("E_pend_push_pop", 32'(fbus.load_pending), 32'd1);
          fdrive(1'b1, 1'b1, 32'ha8);
          #1 check("E_ready_push_pop", 32'(fbus.req_ready), 32'd1);
        end
        3: fdrive(1'b0, 1'b0, 32'h0);
        4: check("E_pend_empty", 32'(fbus.load_pending), 32'd0);
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
